// File: rtl/path_reader_pkg.sv
// Definitions shared by the path reader and its capture buffer.
package path_reader_pkg;

    localparam int COORD_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/path_buf.sv
// Capture buffer for popped coordinates: synchronous write, asynchronous read, no reset on storage.
module path_buf
    import path_reader_pkg::*;
#(
    parameter int W     = COORD_W,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [2*W-1:0]  wdata,
    input  logic [AW-1:0]   raddr,
    output logic [2*W-1:0]  rdata
);

    logic [2*W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/path_reader.sv
// Drains the coordinate stack into a capture buffer, then replays the captured
// path oldest-first on a valid/ready stream.
module path_reader
    import path_reader_pkg::*;
#(
    parameter int W     = COORD_W,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          stkPop,
    input  logic [W-1:0]  stkX,
    input  logic [W-1:0]  stkY,
    input  logic          stkEmpty,
    output logic          outValid,
    input  logic          outReady,
    output logic [W-1:0]  outX,
    output logic [W-1:0]  outY,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH - 1);

    state_e          state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   rdIdx_q, rdIdx_d;
    logic            overflow_q, overflow_d;
    logic [2*W-1:0]  out_q, out_d;
    logic            stkPop_q, stkPop_d;
    logic            outValid_q, outValid_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            bufWe;
    logic [AW-1:0]   bufWaddr;
    logic [AW-1:0]   bufRaddr;
    logic [2*W-1:0]  bufWdata;
    logic [2*W-1:0]  bufRdata;

    path_buf #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (bufWe),
        .waddr (bufWaddr),
        .wdata (bufWdata),
        .raddr (bufRaddr),
        .rdata (bufRdata)
    );

    // Replay runs backwards through the buffer: the last entry popped is the
    // oldest push, so it is presented first.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rdIdx_d    = rdIdx_q;
        overflow_d = overflow_q;
        out_d      = out_q;
        bufWe      = 1'b0;
        bufWaddr   = count_q[AW-1:0];
        bufWdata   = {stkX, stkY};
        bufRaddr   = rdIdx_q - IDX_ONE;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = POP;
                end
            end
            POP: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (stkEmpty) begin
                    if (count_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bufRaddr = count_q[AW-1:0] - IDX_ONE;
                        rdIdx_d  = count_q[AW-1:0] - IDX_ONE;
                        out_d    = bufRdata;
                        state_d  = STREAM;
                    end
                end else begin
                    bufWe   = 1'b1;
                    count_d = count_q + CNT_ONE;
                    if (count_q == CNT_FULL) begin
                        // The final entry is still being written, so present it straight from the stack.
                        overflow_d = 1'b1;
                        rdIdx_d    = IDX_LAST;
                        out_d      = {stkX, stkY};
                        state_d    = STREAM;
                    end else begin
                        state_d = POP;
                    end
                end
            end
            STREAM: begin
                if (outValid_q && outReady) begin
                    if (rdIdx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        rdIdx_d = rdIdx_q - IDX_ONE;
                        out_d   = bufRdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stkPop_d   = (state_d == POP);
        outValid_d = (state_d == STREAM);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rdIdx_q    <= '0;
            overflow_q <= 1'b0;
            out_q      <= '0;
            stkPop_q   <= 1'b0;
            outValid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rdIdx_q    <= rdIdx_d;
            overflow_q <= overflow_d;
            out_q      <= out_d;
            stkPop_q   <= stkPop_d;
            outValid_q <= outValid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign stkPop   = stkPop_q;
    assign outValid = outValid_q;
    assign outX     = out_q[2*W-1:W];
    assign outY     = out_q[W-1:0];
    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_path_reader.sv
// Bench for path_reader: an emulated stack plus a run-level reference model of
// the pop/replay timeline, with literal checks for the directed scenarios.
module tb_path_reader;

    localparam int TW     = 4;
    localparam int TDEPTH = 4;
    localparam int TAW    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stkPop;
    logic [TW-1:0]   stkX = '0;
    logic [TW-1:0]   stkY = '0;
    logic            stkEmpty = 1'b0;
    logic            outValid;
    logic            outReady = 1'b0;
    logic [TW-1:0]   outX;
    logic [TW-1:0]   outY;
    logic [TAW:0]    count;
    logic            busy;
    logic            done;
    logic            overflow;

    path_reader #(
        .W     (TW),
        .DEPTH (TDEPTH),
        .AW    (TAW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stkPop   (stkPop),
        .stkX     (stkX),
        .stkY     (stkY),
        .stkEmpty (stkEmpty),
        .outValid (outValid),
        .outReady (outReady),
        .outX     (outX),
        .outY     (outY),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int         nVec = 0;
    int         nErr = 0;
    logic [7:0] stk[$];
    int         popCount = 0;
    logic [7:0] seenBeats[$];
    bit         validEver = 1'b0;

    int         mCyc = -1;
    int         mPops = 0;
    bit         mStream = 1'b0;
    bit         mDone = 1'b0;
    logic [7:0] mBeats[$];
    int         mCount = 0;
    bit         mOvf = 1'b0;
    int         mRemain = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nErr++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Stack emulator: answers a pop one cycle later, keeping the stack in a queue (back = top).
    always @(posedge clk) begin
        bit popSeen;
        logic [7:0] e;
        popSeen = (stkPop === 1'b1);
        #1;
        if (popSeen) begin
            popCount++;
            if (stk.size() > 0) begin
                e        = stk.pop_back();
                stkX     = e[7:4];
                stkY     = e[3:0];
                stkEmpty = 1'b0;
            end else begin
                stkEmpty = 1'b1;
                stkX     = TW'($urandom);
                stkY     = TW'($urandom);
            end
        end
    end

    // A run captures the top min(size, DEPTH) entries and replays them in push order.
    task automatic startRun();
        int sz;
        int n;
        sz = stk.size();
        n = (sz < TDEPTH) ? sz : TDEPTH;
        mPops = n + ((sz < TDEPTH) ? 1 : 0);
        mBeats.delete();
        for (int i = sz - n; i < sz; i++) mBeats.push_back(stk[i]);
        mCount = n;
        mOvf = (sz >= TDEPTH);
        mRemain = sz - n;
        mCyc = 1;
    endtask

    // Compare at negedge, then advance the model with the inputs the next posedge will sample.
    always @(negedge clk) begin
        bit expPop;
        if (!rst) begin
            mCyc = -1; mStream = 1'b0; mDone = 1'b0; mBeats.delete();
            mCount = 0; mOvf = 1'b0;
            checkOutput("rstValid", outValid, 0);
            checkOutput("rstBusy", busy, 0);
            checkOutput("rstPop", stkPop, 0);
        end else begin
            expPop = (mCyc > 0) && !mStream && !mDone && (mCyc % 2 == 1) && (mCyc <= 2 * mPops - 1);
            checkOutput("busy", busy, mCyc >= 0);
            checkOutput("stkPop", stkPop, expPop);
            checkOutput("outValid", outValid, mStream);
            checkOutput("done", done, mDone);
            if (mStream) begin
                checkOutput("outX", outX, mBeats[0][7:4]);
                checkOutput("outY", outY, mBeats[0][3:0]);
            end
            if (mCyc < 0 || mDone) begin
                checkOutput("count", count, mCount);
                checkOutput("overflow", overflow, mOvf);
            end
            if (outValid === 1'b1) validEver = 1'b1;

            if (mDone) begin
                mDone = 1'b0;
                mCyc = -1;
            end else if (mCyc < 0) begin
                if (start) startRun();
            end else if (mStream) begin
                if (outReady) begin
                    if (outValid === 1'b1) seenBeats.push_back({outX, outY});
                    void'(mBeats.pop_front());
                    if (mBeats.size() == 0) begin
                        mStream = 1'b0;
                        mDone = 1'b1;
                    end
                end
            end else begin
                mCyc++;
                if (mCyc == 2 * mPops + 1) begin
                    if (mBeats.size() == 0) mDone = 1'b1;
                    else mStream = 1'b1;
                end
            end
        end
    end

    // mode 0: ready held high; 1: random ready; 2: 5-cycle stall on beat (3,4); 3: random ready plus start pulses while streaming
    task automatic applyStimulus(input int mode);
        int stall;
        bit stalled;
        bit sawDone;
        stall = 0; stalled = 1'b0; sawDone = 1'b0;
        popCount = 0; seenBeats.delete(); validEver = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        outReady = (mode == 1 || mode == 3) ? 1'($urandom_range(1)) : 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && !sawDone; c++) begin
            @(posedge clk); #1;
            if (done) sawDone = 1'b1;
            case (mode)
                1: outReady = 1'($urandom_range(1));
                2: begin
                    if (!stalled && outValid && outX == 4'd3 && outY == 4'd4) begin
                        outReady = 1'b0; stall = 5; stalled = 1'b1;
                    end else if (stall > 0) begin
                        stall--;
                        outReady = (stall == 0);
                    end
                end
                3: begin
                    outReady = 1'($urandom_range(1));
                    start = outValid;
                end
                default: outReady = 1'b1;
            endcase
        end
        start = 1'b0;
        if (!sawDone) checkOutput("doneTimeout", 0, 1);
    endtask

    task automatic loadStack(input int n, input bit diag);
        stk.delete();
        for (int i = 1; i <= n; i++) begin
            if (diag) stk.push_back({4'(i), 4'(i)});
            else stk.push_back(8'($urandom));
        end
    endtask

    task automatic checkBeats(input string name, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        checkOutput({name, "Len"}, seenBeats.size(), 3);
        if (seenBeats.size() == 3) begin
            checkOutput({name, "B0"}, seenBeats[0], a);
            checkOutput({name, "B1"}, seenBeats[1], b);
            checkOutput({name, "B2"}, seenBeats[2], c);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstCount", count, 0);
        checkOutput("rstOutX", outX, 0);
        checkOutput("rstOutY", outY, 0);
        checkOutput("rstOvf", overflow, 0);
        checkOutput("rstDone", done, 0);
        rst = 1'b1;

        $display("[TB] three entries, ready held high");
        stk = '{8'h12, 8'h34, 8'h56};
        applyStimulus(0);
        checkOutput("s1Pops", popCount, 4);
        checkOutput("s1Count", count, 3);
        checkOutput("s1Ovf", overflow, 0);
        checkBeats("s1", 8'h12, 8'h34, 8'h56);

        $display("[TB] empty stack");
        stk.delete();
        applyStimulus(0);
        checkOutput("s2Pops", popCount, 1);
        checkOutput("s2Count", count, 0);
        checkOutput("s2ValidEver", validEver, 0);

        $display("[TB] stall on second beat");
        stk = '{8'h12, 8'h34, 8'h56};
        applyStimulus(2);
        checkBeats("s3", 8'h12, 8'h34, 8'h56);

        $display("[TB] overflow with six entries");
        loadStack(6, 1'b1);
        applyStimulus(0);
        checkOutput("s4Pops", popCount, 4);
        checkOutput("s4Ovf", overflow, 1);
        checkOutput("s4Count", count, 4);
        checkOutput("s4Beats", seenBeats.size(), 4);
        if (seenBeats.size() == 4) begin
            checkOutput("s4B0", seenBeats[0], 8'h33);
            checkOutput("s4B3", seenBeats[3], 8'h66);
        end
        checkOutput("s4Left", stk.size(), 2);
        if (stk.size() == 2) begin
            checkOutput("s4Left0", stk[0], 8'h11);
            checkOutput("s4Left1", stk[1], 8'h22);
        end

        $display("[TB] reset during replay");
        stk = '{8'h12, 8'h34, 8'h56};
        @(posedge clk); #1;
        start = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && !outValid; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("s5ReachedStream", outValid, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("s5AsyncValid", outValid, 0);
        checkOutput("s5AsyncBusy", busy, 0);
        checkOutput("s5AsyncPop", stkPop, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        stk = '{8'h78, 8'h9a, 8'hbc};
        applyStimulus(0);
        checkBeats("s5", 8'h78, 8'h9a, 8'hbc);

        $display("[TB] start pulses during replay");
        stk = '{8'h12, 8'h34, 8'h56};
        applyStimulus(3);
        checkBeats("s6", 8'h12, 8'h34, 8'h56);
        checkOutput("s6Count", count, 3);

        $display("[TB] randomized runs");
        for (int r = 0; r < 30; r++) begin
            loadStack($urandom_range(6), 1'b0);
            applyStimulus(($urandom_range(1) == 1) ? 3 : 1);
            checkOutput("rndLeft", stk.size(), mRemain);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/path_reader.md
Name: path_reader

Overview:
- Consumer/reader side of the coordinate stack: drains the stack by issuing pops, captures each returned (x,y) pair, then replays the path in push order (oldest first) on a valid/ready stream.
- Sits between the coordinate stack and downstream path consumers (display/route output), and owns the stack's pop port while active.
- Each stack pop returns data on the cycle after the pop. Empty is reported on the cycle after a pop issued to an empty stack.

Parameters:
- W, 4, coordinate width per axis (matches stack x/y width)
- DEPTH, 64, capture buffer entries
- AW, 6, index width, clog2(DEPTH)

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst  input  1  reset, asynchronous, active-low (rst=0 resets)
- start  input  1  begin drain+replay; sampled only in IDLE
- stkPop  output  1  pop request to stack, one-cycle pulse per entry
- stkX  input  W  stack x data, valid the cycle after stkPop
- stkY  input  W  stack y data, valid the cycle after stkPop
- stkEmpty  input  1  stack empty flag, valid the cycle after stkPop
- outValid  output  1  replay beat valid
- outReady  input  1  downstream accepts beat
- outX  output  W  replay x
- outY  output  W  replay y
- count  output  AW+1  entries captured in current run
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at run end
- overflow  output  1  buffer filled before stack empty; sticky until next start

Behaviour:
- Reset (rst=0, async): state IDLE; stkPop, outValid, done, overflow, count, outX, outY all 0. Buffer contents don't care.
- All outputs registered. Reset mid-run aborts immediately: outValid drops without a handshake, and the stack is left partially drained.
- IDLE: start=1 -> clear count/overflow, go POP. start in any other state is ignored.
- POP: stkPop=1 for exactly this cycle -> WAIT.
- WAIT: stkPop=0; sample the stack response.
  - stkEmpty=1 and count==0 -> DONE (no beats emitted).
  - stkEmpty=1 and count>0 -> load rdIdx=count-1, go STREAM.
  - stkEmpty=0 -> buf[count]={stkX,stkY}, count++. If the new count==DEPTH: overflow=1, go STREAM. Else go POP.
- Pair (0,0) is a legal coordinate. Only stkEmpty terminates the drain.
- Drain throughput: 1 entry per 2 cycles.
- STREAM: outValid=1, {outX,outY}=buf[rdIdx].
  - Transfer occurs on a posedge with outValid&outReady.
  - On transfer with rdIdx>0: rdIdx--, next beat presented the following cycle (1 beat/cycle under constant ready).
  - On transfer with rdIdx==0: outValid=0, go DONE.
  - While outReady=0: outX/outY/outValid held stable.
- DONE: done=1 one cycle -> IDLE. count holds its final value until the next start.
- Order: last-popped entry is emitted first, so the output sequence equals the original push order.

Decomposition:
- Shared package: state encoding constants (IDLE, POP, WAIT, STREAM, DONE) and coordinate width W, shared with the stack.
- One sub-module, path_buf: DEPTH x 2W register file, synchronous write (we, waddr, wdata), asynchronous read (raddr, rdata), no reset on storage.
- FSM, counters and handshake stay in path_reader.

Test Plan:
- Stack preloaded with pushes (1,2),(3,4),(5,6), outReady=1, start pulse -> 4 stkPop pulses 2 cycles apart; beats (1,2),(3,4),(5,6) on consecutive cycles; done pulse; count=3; overflow=0.
- Empty stack, start -> exactly 1 stkPop, stkEmpty next cycle, done pulse, outValid never asserted, count=0.
- Same 3 entries, outReady=0 for 5 cycles while beat (3,4) is presented -> outX=3, outY=4, outValid=1 held all 5 cycles; no beat lost or duplicated.
- DEPTH=4, stack holds pushes 1..6 as (n,n) -> 4 pops, overflow=1, beats (3,3),(4,4),(5,5),(6,6), done; stack still holds (1,1),(2,2).
- rst=0 asserted asynchronously mid-STREAM -> outValid/busy/stkPop go to 0 before the next clk edge; after release, a new start runs normally.
- start pulsed again during STREAM -> ignored; the beat sequence and count are unchanged.
